ks_multiword_add_seq: RTL

//  Multi-precision add sequencer around kogge_stone_adder: accepts two wide operands
//  (NUM_LIMBS x LIMB_W bits) over valid/ready, feeds the adder one limb per cycle
//  LSB-first, and chains cout of limb i into cin of limb i+1.

---
 rtl/ks_pkg.sv | 23 ++
 rtl/kogge_stone_adder.sv | 52 +++++
 rtl/ks_multiword_add_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// ks_pkg
//   Shared types and defaults for the multi-word Kogge-Stone add sequencer.
//   - ks_seq_state_e : sequencer FSM states (IDLE, RUN, DONE)
//   - LIMB_W_DEF     : default limb width (matches the adder width)
//   - NUM_LIMBS_DEF  : default number of limbs per operand
//   - idx_width()    : width of the limb index register, never below 1 bit
package ks_pkg;

  localparam int LIMB_W_DEF    = 8;
  localparam int NUM_LIMBS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ks_seq_state_e;

  // A single-limb configuration still needs a 1-bit index so the register exists.
  function automatic int idx_width(input int num_limbs);
    return (num_limbs <= 1) ? 1 : $clog2(num_limbs);
  endfunction

endpackage

// File: rtl/kogge_stone_adder.sv
// kogge_stone_adder
//   Single-width combinational adder built on a Kogge-Stone parallel prefix
//   network: sum = a + b + cin, with the carry out of the top bit on cout.
// Ports
//   a    in  W  addend A
//   b    in  W  addend B
//   cin  in  1  carry into bit 0
//   sum  out W  (a + b + cin) mod 2^W
//   cout out 1  carry out of bit W-1
module kogge_stone_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] prop;
  logic [W-1:0] grp_g;
  logic [W-1:0] grp_p;
  logic [W-1:0] nxt_g;
  logic [W-1:0] nxt_p;
  logic [W:0]   carries;

  // Prefix tree. cin is folded into the bit-0 generate term, so after the
  // last level grp_g[i] is the carry out of bit i including cin. Each level
  // combines every (G,P) pair with the pair d positions below it, doubling d.
  always_comb begin
    prop  = a ^ b;
    grp_g = a & b;
    grp_p = prop;
    grp_g[0] = grp_g[0] | (prop[0] & cin);
    nxt_g = grp_g;
    nxt_p = grp_p;
    for (int d = 1; d < W; d = d * 2) begin
      nxt_g = grp_g;
      nxt_p = grp_p;
      for (int i = d; i < W; i++) begin
        nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        nxt_p[i] = grp_p[i] & grp_p[i-d];
      end
      grp_g = nxt_g;
      grp_p = nxt_p;
    end
    carries = {grp_g, cin};
    sum     = prop ^ carries[W-1:0];
    cout    = carries[W];
  end

endmodule

// File: rtl/ks_multiword_add_seq.sv
// ks_multiword_add_seq
//   Sequential wide adder. Accepts two NUM_LIMBS x LIMB_W operands, pushes
//   them through a single kogge_stone_adder one limb per cycle starting at
//   the least significant limb, chaining each limb's carry into the next,
//   and presents {cout_o, sum_o} until the consumer takes it.
// Ports
//   clk       in  1  rising-edge clock
//   rst       in  1  synchronous active-high reset
//   in_valid  in  1  operand request valid
//   in_ready  out 1  sequencer idle and able to take a request
//   a_i       in  N  operand A (N = LIMB_W*NUM_LIMBS)
//   b_i       in  N  operand B
//   cin_i     in  1  carry into limb 0
//   out_valid out 1  result valid
//   out_ready in  1  consumer accepts result
//   sum_o     out N  (a_i + b_i + cin_i) mod 2^N
//   cout_o    out 1  bit N of a_i + b_i + cin_i
//   busy      out 1  operation in flight or result waiting
module ks_multiword_add_seq
  import ks_pkg::*;
#(
  parameter int LIMB_W    = LIMB_W_DEF,
  parameter int NUM_LIMBS = NUM_LIMBS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LIMB_W*NUM_LIMBS-1:0] a_i,
  input  logic [LIMB_W*NUM_LIMBS-1:0] b_i,
  input  logic                        cin_i,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LIMB_W*NUM_LIMBS-1:0] sum_o,
  output logic                        cout_o,
  output logic                        busy
);

  localparam int N     = LIMB_W * NUM_LIMBS;
  localparam int IDX_W = idx_width(NUM_LIMBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  ks_seq_state_e state;
  ks_seq_state_e state_next;

  logic [N-1:0]      a_reg;
  logic [N-1:0]      b_reg;
  logic [IDX_W-1:0]  limb_idx;
  logic              carry;
  logic [LIMB_W-1:0] a_limb;
  logic [LIMB_W-1:0] b_limb;
  logic [LIMB_W-1:0] ksa_sum;
  logic              ksa_cout;
  logic              accept;
  logic              last_limb;

  // Handshake flags come straight from the state so they never glitch on
  // datapath activity; reset forces in_ready low even from IDLE.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_limb = (limb_idx == LAST_IDX);

  assign a_limb = a_reg[int'(limb_idx)*LIMB_W +: LIMB_W];
  assign b_limb = b_reg[int'(limb_idx)*LIMB_W +: LIMB_W];

  kogge_stone_adder #(
    .W (LIMB_W)
  ) u_ksa (
    .a    (a_limb),
    .b    (b_limb),
    .cin  (carry),
    .sum  (ksa_sum),
    .cout (ksa_cout)
  );

  // State register; reset also aborts any operation in RUN or DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: IDLE -> RUN on accept, RUN -> DONE after the top
  // limb, DONE -> IDLE on the output handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)                 state_next = RUN;
      RUN:  if (last_limb)              state_next = DONE;
      DONE: if (out_valid && out_ready) state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // Datapath. Operands are captured only on accept, so later changes on the
  // inputs cannot disturb a running add. The result registers are written
  // only in RUN and therefore hold through DONE and the following IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      limb_idx <= '0;
      carry    <= 1'b0;
      sum_o    <= '0;
      cout_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg    <= a_i;
            b_reg    <= b_i;
            carry    <= cin_i;
            limb_idx <= '0;
          end
        end
        RUN: begin
          sum_o[int'(limb_idx)*LIMB_W +: LIMB_W] <= ksa_sum;
          carry <= ksa_cout;
          if (last_limb) begin
            cout_o   <= ksa_cout;
            limb_idx <= '0;
          end else begin
            limb_idx <= limb_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
